// File: rtl/hyper_din_burst_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant lasts until the requester's last beat or MAX_BURST transferred beats.
module hyper_din_burst_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [DATA_WIDTH-1:0]            fifo_data,
    output logic                             fifo_valid,
    input  logic                             fifo_ready,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             busy,
    output logic [$clog2(MAX_BURST+1)-1:0]   beat_cnt
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     gidx_q, gidx_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;

    logic                sel_found;
    logic [IdxW-1:0]     sel_idx;
    logic [IdxW-1:0]     next_ptr;
    logic                xfer;
    logic                cur_last;
    logic                burst_end;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(rr_ptr_q) + off) % NUM_REQ;
            if (!sel_found && req_valid[cand[IdxW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IdxW-1:0];
            end
        end
    end

    // Forwarding is an AND-OR mux on the one-hot grant, so an idle port reads as zero.
    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_data = fifo_data
                      | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
        end
    end

    assign fifo_valid = |(req_valid & grant_q);
    assign req_ready  = grant_q & {NUM_REQ{fifo_ready}};
    assign cur_last   = |(req_last & grant_q);
    assign xfer       = fifo_valid & fifo_ready;
    assign burst_end  = xfer & (cur_last | (beat_cnt_q == CntW'(MAX_BURST - 1)));
    assign next_ptr   = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + IdxW'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d    = StBurst;
                    grant_d    = NUM_REQ'(1) << sel_idx;
                    gidx_d     = sel_idx;
                    beat_cnt_d = '0;
                end
            end
            StBurst: begin
                if (burst_end) begin
                    state_d    = StIdle;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = next_ptr;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                grant_d    = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q == StBurst);
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_hyper_din_burst_arbiter.sv
// Scoreboard bench for hyper_din_burst_arbiter: requester queues feed the DUT, expected beats
// are queued with the stimulus and compared against beats captured at the FIFO port.
module tb_hyper_din_burst_arbiter;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned DW        = 10;
    localparam int unsigned MAX_BURST = 16;
    localparam int unsigned CW        = $clog2(MAX_BURST + 1);
    localparam int          LIMIT     = 400;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } src_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic [CW-1:0] bc;
        int            cyc;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic [DW-1:0]          fifo_data;
    logic                   fifo_valid;
    logic                   fifo_ready;
    logic [NUM_REQ-1:0]     grant;
    logic                   busy;
    logic [CW-1:0]          beat_cnt;

    logic [1:0] en;
    src_t       src0[$];
    src_t       src1[$];
    beat_t      exp_q[$];
    beat_t      obs_q[$];
    int         cyc_n;
    int         n_checks;
    int         n_fail;

    hyper_din_burst_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_ready (fifo_ready),
        .grant      (grant),
        .busy       (busy),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic present();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        if (en[0] && src0.size() > 0) begin
            req_valid[0]     = 1'b1;
            req_last[0]      = src0[0].last;
            req_data[DW-1:0] = src0[0].data;
        end
        if (en[1] && src1.size() > 0) begin
            req_valid[1]        = 1'b1;
            req_last[1]         = src1[0].last;
            req_data[2*DW-1:DW] = src1[0].data;
        end
    endtask

    // Sample handshakes mid-cycle; they complete on the following rising edge.
    task automatic cycle();
        beat_t o;
        logic  hs0, hs1;
        @(negedge clk);
        cyc_n++;
        hs0 = req_valid[0] && req_ready[0];
        hs1 = req_valid[1] && req_ready[1];
        if (!rst && fifo_valid && fifo_ready) begin
            o.idx  = (grant == 2'b01) ? 0 : ((grant == 2'b10) ? 1 : -1);
            o.data = fifo_data;
            o.bc   = beat_cnt;
            o.cyc  = cyc_n;
            obs_q.push_back(o);
        end
        @(posedge clk);
        #1;
        if (hs0 && src0.size() > 0) src0.delete(0);
        if (hs1 && src1.size() > 0) src1.delete(0);
        present();
    endtask

    task automatic push_src(input int which, input int data, input bit last);
        src_t s;
        s.data = DW'(data);
        s.last = last;
        if (which == 0) src0.push_back(s);
        else            src1.push_back(s);
    endtask

    task automatic push_exp(input int idx, input int data, input int bc);
        beat_t e;
        e.idx  = idx;
        e.data = DW'(data);
        e.bc   = CW'(bc);
        e.cyc  = 0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        fifo_ready = 1'b1;
        en         = 2'b00;
        src0.delete();
        src1.delete();
        present();
        cycle();
        cycle();
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        beat_t e, o;
        fifo_ready = 1'b1;
        push_src(0, 'h0A1, 1'b1);
        push_src(1, 'h0B1, 1'b1);
        en = 2'b11;
        present();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (grant !== 2'b00 || fifo_valid !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b0
                || beat_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: grant=%b fifo_valid=%b req_ready=%b busy=%b beat_cnt=%0d, required 00/0/00/0/0",
                         grant, fifo_valid, req_ready, busy, beat_cnt);
            end
        end
        rst = 1'b0;
        push_exp(0, 'h0A1, 0);
        push_exp(1, 'h0B1, 0);
        cycle();
        n_checks++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: grant=%b busy=%b, required 01/1", grant, busy);
        end
        for (int i = 0; i < LIMIT && (src0.size() > 0 || src1.size() > 0); i++) cycle();
        n_checks++;
        if (src0.size() + src1.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain: %0d beats pending, required 0", src0.size() + src1.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_beat: missing beat, required req%0d data %h", e.idx, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.idx !== e.idx || o.data !== e.data || o.bc !== e.bc) begin
                    n_fail++;
                    $display("FAIL reset_beat: got req%0d data %h cnt %0d, required req%0d data %h cnt %0d",
                             o.idx, o.data, o.bc, e.idx, e.data, e.bc);
                end
            end
        end
    endtask

    task automatic test_single_burst();
        beat_t e, o;
        int    prev;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            push_src(0, k, k == 4);
            push_exp(0, k, k - 1);
        end
        en = 2'b01;
        present();
        for (int i = 0; i < LIMIT && src0.size() > 0; i++) cycle();
        n_checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || fifo_data !== '0 || fifo_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle_gap: grant=%b busy=%b data=%h valid=%b, required 00/0/000/0",
                     grant, busy, fifo_data, fifo_valid);
        end
        // rr_ptr now points at req1, so it must win the simultaneous request.
        push_src(0, 'h0AA, 1'b1);
        push_src(1, 'h0BB, 1'b1);
        push_exp(1, 'h0BB, 0);
        push_exp(0, 'h0AA, 0);
        en = 2'b11;
        present();
        for (int i = 0; i < LIMIT && (src0.size() > 0 || src1.size() > 0); i++) cycle();
        n_checks++;
        if (src0.size() + src1.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain: %0d beats pending, required 0", src0.size() + src1.size());
        end
        prev = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_beat: missing beat, required req%0d data %h", e.idx, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.idx !== e.idx || o.data !== e.data || o.bc !== e.bc) begin
                    n_fail++;
                    $display("FAIL single_beat: got req%0d data %h cnt %0d, required req%0d data %h cnt %0d",
                             o.idx, o.data, o.bc, e.idx, e.data, e.bc);
                end
                if (prev >= 0) begin
                    n_checks++;
                    if (o.cyc - prev !== ((e.bc == 0) ? 2 : 1)) begin
                        n_fail++;
                        $display("FAIL single_gap: beat %h came %0d cycles after previous, required %0d",
                                 o.data, o.cyc - prev, (e.bc == 0) ? 2 : 1);
                    end
                end
                prev = o.cyc;
            end
        end
    endtask

    task automatic test_round_robin();
        beat_t e, o;
        int    prev;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            push_src(0, 'h100 + 2*b, 1'b0);
            push_src(0, 'h101 + 2*b, 1'b1);
            push_src(1, 'h200 + 2*b, 1'b0);
            push_src(1, 'h201 + 2*b, 1'b1);
            push_exp(0, 'h100 + 2*b, 0);
            push_exp(0, 'h101 + 2*b, 1);
            push_exp(1, 'h200 + 2*b, 0);
            push_exp(1, 'h201 + 2*b, 1);
        end
        en = 2'b11;
        present();
        for (int i = 0; i < LIMIT && (src0.size() > 0 || src1.size() > 0); i++) cycle();
        n_checks++;
        if (src0.size() + src1.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: %0d beats pending, required 0", src0.size() + src1.size());
        end
        prev = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rr_beat: missing beat, required req%0d data %h", e.idx, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.idx !== e.idx || o.data !== e.data || o.bc !== e.bc) begin
                    n_fail++;
                    $display("FAIL rr_beat: got req%0d data %h cnt %0d, required req%0d data %h cnt %0d",
                             o.idx, o.data, o.bc, e.idx, e.data, e.bc);
                end
                if (prev >= 0) begin
                    n_checks++;
                    if (o.cyc - prev !== ((e.bc == 0) ? 2 : 1)) begin
                        n_fail++;
                        $display("FAIL rr_gap: beat %h came %0d cycles after previous, required %0d",
                                 o.data, o.cyc - prev, (e.bc == 0) ? 2 : 1);
                    end
                end
                prev = o.cyc;
            end
        end
    endtask

    task automatic test_max_burst();
        beat_t e, o;
        int    prev;
        do_reset();
        // Beat 31 closes the second grant by last and by the cap at once.
        for (int k = 0; k < 40; k++) push_src(0, 'h300 + k, (k == 31) || (k == 39));
        push_src(1, 'h050, 1'b0);
        push_src(1, 'h051, 1'b1);
        for (int k = 0; k < 16; k++) push_exp(0, 'h300 + k, k);
        push_exp(1, 'h050, 0);
        push_exp(1, 'h051, 1);
        for (int k = 16; k < 32; k++) push_exp(0, 'h300 + k, k - 16);
        for (int k = 32; k < 40; k++) push_exp(0, 'h300 + k, k - 32);
        en = 2'b11;
        present();
        for (int i = 0; i < LIMIT && (src0.size() > 0 || src1.size() > 0); i++) cycle();
        n_checks++;
        if (src0.size() + src1.size() != 0) begin
            n_fail++;
            $display("FAIL cap_drain: %0d beats pending, required 0", src0.size() + src1.size());
        end
        prev = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL cap_beat: missing beat, required req%0d data %h", e.idx, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.idx !== e.idx || o.data !== e.data || o.bc !== e.bc) begin
                    n_fail++;
                    $display("FAIL cap_beat: got req%0d data %h cnt %0d, required req%0d data %h cnt %0d",
                             o.idx, o.data, o.bc, e.idx, e.data, e.bc);
                end
                if (prev >= 0) begin
                    n_checks++;
                    if (o.cyc - prev !== ((e.bc == 0) ? 2 : 1)) begin
                        n_fail++;
                        $display("FAIL cap_gap: beat %h came %0d cycles after previous, required %0d",
                                 o.data, o.cyc - prev, (e.bc == 0) ? 2 : 1);
                    end
                end
                prev = o.cyc;
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t e, o;
        int    i;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push_src(0, 'h010 + k, k == 5);
            push_exp(0, 'h010 + k, k);
        end
        en = 2'b01;
        present();
        for (i = 0; i < LIMIT && obs_q.size() < 2; i++) cycle();
        n_checks++;
        if (obs_q.size() < 2) begin
            n_fail++;
            $display("FAIL bp_start: %0d beats seen before stall, required 2", obs_q.size());
        end
        fifo_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            cycle();
            n_checks++;
            if (fifo_valid !== 1'b1 || fifo_data !== DW'('h012) || beat_cnt !== CW'(2)
                || grant !== 2'b01) begin
                n_fail++;
                $display("FAIL bp_stall: valid=%b data=%h cnt=%0d grant=%b, required 1/012/2/01",
                         fifo_valid, fifo_data, beat_cnt, grant);
            end
        end
        fifo_ready = 1'b1;
        for (i = 0; i < LIMIT && src0.size() > 0; i++) cycle();
        n_checks++;
        if (src0.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d beats pending, required 0", src0.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL bp_beat: missing beat, required req%0d data %h", e.idx, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.idx !== e.idx || o.data !== e.data || o.bc !== e.bc) begin
                    n_fail++;
                    $display("FAIL bp_beat: got req%0d data %h cnt %0d, required req%0d data %h cnt %0d",
                             o.idx, o.data, o.bc, e.idx, e.data, e.bc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_extra: %0d unexpected beats, required 0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        beat_t e, o;
        do_reset();
        for (int k = 0; k < 8; k++) push_src(1, 'h020 + k, k == 7);
        for (int k = 0; k < 3; k++) push_exp(1, 'h020 + k, k);
        en = 2'b10;
        present();
        for (int i = 0; i < LIMIT && obs_q.size() < 3; i++) cycle();
        rst = 1'b1;
        cycle();
        n_checks++;
        if (grant !== 2'b00 || beat_cnt !== '0 || busy !== 1'b0 || fifo_valid !== 1'b0
            || fifo_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: grant=%b cnt=%0d busy=%b valid=%b data=%h, required 00/0/0/0/000",
                     grant, beat_cnt, busy, fifo_valid, fifo_data);
        end
        src1.delete();
        push_src(0, 'h0C0, 1'b1);
        push_src(1, 'h0C1, 1'b1);
        push_exp(0, 'h0C0, 0);
        push_exp(1, 'h0C1, 0);
        rst = 1'b0;
        en  = 2'b11;
        present();
        for (int i = 0; i < LIMIT && (src0.size() > 0 || src1.size() > 0); i++) cycle();
        n_checks++;
        if (src0.size() + src1.size() != 0) begin
            n_fail++;
            $display("FAIL mid_drain: %0d beats pending, required 0", src0.size() + src1.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL mid_beat: missing beat, required req%0d data %h", e.idx, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.idx !== e.idx || o.data !== e.data || o.bc !== e.bc) begin
                    n_fail++;
                    $display("FAIL mid_beat: got req%0d data %h cnt %0d, required req%0d data %h cnt %0d",
                             o.idx, o.data, o.bc, e.idx, e.data, e.bc);
                end
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc_n      = 0;
        fifo_ready = 1'b1;
        en         = 2'b00;
        present();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
